// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
package mcycle_pkg;

  localparam int unsigned MCYCLE_WIDTH = 32;

  localparam logic [1:0] OP_SMUL = 2'b00;
  localparam logic [1:0] OP_UMUL = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_UDIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTING = 2'd1,
    DONE      = 2'd2
  } state_t;

endpackage

// File: rtl/mcycle_sign_fix.sv
// Conditional two's-complement negation: magnitude extraction on the way in and
// sign restoration on the way out.
module mcycle_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit, one bit per cycle, with a combinational Busy stall
// for the program counter.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = MCYCLE_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_op1;
  logic               r_is_div, r_neg_lo, r_neg_hi, r_div0;
  logic [WIDTH-1:0]   r_result1, r_result2;

  logic               w_start, w_last, w_is_div, w_is_signed;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [WIDTH-1:0]   w_diff, w_rem_nxt;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_acc_nxt, w_fix_full;
  logic [WIDTH-1:0]   w_fix_rem, w_res1, w_res2;

  assign w_is_div    = (MCycleOp == OP_SDIV) || (MCycleOp == OP_UDIV);
  assign w_is_signed = (MCycleOp == OP_SMUL) || (MCycleOp == OP_SDIV);
  assign w_start     = (r_state == IDLE) && Start;
  assign w_last      = (r_count == CNT_W'(WIDTH - 1));

  mcycle_sign_fix #(.W(WIDTH)) u_fix_a (
    .i_val (Operand1),
    .i_neg (w_is_signed & Operand1[WIDTH-1]),
    .o_val (w_a_mag)
  );

  mcycle_sign_fix #(.W(WIDTH)) u_fix_b (
    .i_val (Operand2),
    .i_neg (w_is_signed & Operand2[WIDTH-1]),
    .o_val (w_b_mag)
  );

  // Multiply: acc = {partial product, multiplier}; add on lsb, then shift right.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // Divide: acc = {remainder, dividend}; shift left, keep difference if it fits.
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_q_bit   = (w_shift >= {1'b0, r_opnd});
  assign w_diff    = w_shift[WIDTH-1:0] - r_opnd;
  assign w_rem_nxt = w_q_bit ? w_diff : w_shift[WIDTH-1:0];

  assign w_acc_nxt = r_is_div ? {w_rem_nxt, r_acc[WIDTH-2:0], w_q_bit}
                              : {w_sum, r_acc[WIDTH-1:1]};

  // Negating the full 2*WIDTH value also yields the negated quotient in the low half.
  mcycle_sign_fix #(.W(2 * WIDTH)) u_fix_out (
    .i_val (w_acc_nxt),
    .i_neg (r_neg_lo),
    .o_val (w_fix_full)
  );

  mcycle_sign_fix #(.W(WIDTH)) u_fix_rem (
    .i_val (w_acc_nxt[2*WIDTH-1:WIDTH]),
    .i_neg (r_neg_hi),
    .o_val (w_fix_rem)
  );

  always_comb begin
    w_res1 = w_fix_full[WIDTH-1:0];
    w_res2 = w_fix_full[2*WIDTH-1:WIDTH];
    if (r_is_div && r_div0) begin
      w_res1 = '1;
      w_res2 = r_op1;
    end else if (r_is_div) begin
      w_res2 = w_fix_rem;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    Busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_state_nxt = COMPUTING;
          Busy        = 1'b1;
        end
      end
      COMPUTING: begin
        Busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_count   <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_op1     <= '0;
      r_is_div  <= 1'b0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_div0    <= 1'b0;
      r_result1 <= '0;
      r_result2 <= '0;
    end else if (w_start) begin
      r_count  <= '0;
      r_is_div <= w_is_div;
      r_neg_lo <= w_is_signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
      r_neg_hi <= w_is_signed & w_is_div & Operand1[WIDTH-1];
      r_div0   <= (Operand2 == '0);
      r_op1    <= Operand1;
      r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
      r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
    end else if (r_state == COMPUTING) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + CNT_W'(1);
      if (w_last) begin
        r_result1 <= w_res1;
        r_result2 <= w_res2;
      end
    end
  end

  assign Result1 = r_result1;
  assign Result2 = r_result2;

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: the driver queues expected results, a monitor
// checks them (and the busy length) each time Busy falls.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  localparam int unsigned W = 32;
  localparam int BUSY_LEN = 33;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1, Operand2;
  logic [W-1:0] Result1, Result2;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    int           id;
  } exp_t;

  exp_t sb[$];

  mcycle_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int id, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, got, exp);
    end
  endtask

  // Monitor: counts Busy-high samples and checks results on each falling Busy.
  initial begin
    int   cnt;
    bit   prev;
    exp_t e;
    cnt  = 0;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        cnt  = 0;
        prev = 1'b0;
      end else if (Busy) begin
        cnt++;
        prev = 1'b1;
      end else if (prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got result %h expected none", Result1);
        end else begin
          e = sb.pop_front();
          check("result1", e.id, Result1, e.r1);
          check("result2", e.id, Result2, e.r2);
          check("busy_cycles", e.id, W'(cnt), W'(BUSY_LEN));
        end
        cnt  = 0;
        prev = 1'b0;
      end
    end
  end

  // Issue one operation and return in the DONE cycle (Busy observed low).
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e1, input logic [W-1:0] e2, input bit hold,
                        input bit drop_mid, input int id);
    exp_t e;
    bit   done;
    @(posedge CLK);
    #1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    e.r1 = e1;
    e.r2 = e2;
    e.id = id;
    sb.push_back(e);
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge CLK);
      done = !Busy;
      #1;
      if (n == 3) begin
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = 2'($urandom_range(0, 3));
      end
      if (drop_mid && n == 5) Start = 1'b0;
      if (done && !hold) Start = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout vec%0d: got Busy %b expected 0", id, Busy);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    MCycleOp = 2'b00;
    Operand1 = '0;
    Operand2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", 0, W'(Busy), W'(0));
    check("reset_result1", 0, Result1, '0);
    check("reset_result2", 0, Result2, '0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    run_op(OP_UMUL, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 1);
    // Start stays high across DONE: the next operation starts in the following IDLE cycle.
    run_op(OP_SMUL, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
    run_op(OP_SDIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 3);
    run_op(OP_UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, 4);
    run_op(OP_UDIV, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 1'b0, 5);
    run_op(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 6);
    run_op(OP_SDIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b0, 7);
    run_op(OP_SMUL, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 1'b0, 1'b0, 8);
    run_op(OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 9);
    run_op(OP_SDIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 10);

    // Abort an operation at cycle 10 of COMPUTING.
    @(posedge CLK);
    #1;
    MCycleOp = OP_UMUL;
    Operand1 = 32'h0000_1111;
    Operand2 = 32'h0000_2222;
    Start    = 1'b1;
    repeat (11) @(posedge CLK);
    #1;
    Start = 1'b0;
    Reset = 1'b1;
    #1;
    check("abort_busy", 11, W'(Busy), W'(0));
    check("abort_result1", 11, Result1, '0);
    check("abort_result2", 11, Result2, '0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    run_op(OP_UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 12);
    run_op(OP_SMUL, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b0, 1'b0, 13);

    repeat (3) @(posedge CLK);
    check("scoreboard_drain", 0, W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Multi-cycle multiply/divide unit for the single-cycle processor core.
- Produces the Busy stall signal consumed by the program counter. While Busy is high, the instruction fetch holds.
- Computes iteratively, one bit per cycle. Results are available when Busy falls.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request from decoder. Held high by the stalled instruction until it retires.
- MCycleOp  input  2  operation select:
  - 00 signed MUL
  - 01 unsigned MUL
  - 10 signed DIV
  - 11 unsigned DIV
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- Result1  output  WIDTH  MUL: low product; DIV: quotient.
- Result2  output  WIDTH  MUL: high product; DIV: remainder.
- Busy  output  1  stall request to the program counter.

Behaviour:
- Clock CLK, reset Reset (asynchronous, active-high); all state elements clear on Reset.
- Reset values:
  - state=IDLE, count=0.
  - Result1=0, Result2=0.
  - Busy=0, provided Start is low.
- FSM states: IDLE, COMPUTING, DONE.
- IDLE:
  - Start=1: latch Operand1, Operand2 and MCycleOp; count<=0; go to COMPUTING.
  - Busy is combinationally high in this same cycle, so the PC stalls on the first edge.
- COMPUTING:
  - One iteration per cycle; Busy=1.
  - When count==WIDTH-1: write Result1/Result2 and go to DONE. Otherwise count<=count+1.
- DONE:
  - Busy=0; the PC advances on this edge.
  - Start is ignored, because it is still high from the retiring instruction.
  - Unconditionally go to IDLE.
- Busy = (state==IDLE & Start) | (state==COMPUTING). Combinational, no register.
- Latency:
  - Busy high for WIDTH+1 consecutive cycles (33 at default).
  - Results valid from the first cycle Busy is low, and held until the next operation's completion write.
- Signed operations:
  - Operate on magnitudes, then correct signs.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Multiply:
  - Shift-add, 2*WIDTH accumulator.
  - Result2:Result1 = full 2*WIDTH product.
- Divide:
  - Restoring, one quotient bit per cycle, MSB first.
- Divide by zero (signed and unsigned):
  - Result1 = all ones; Result2 = Operand1.
  - Full latency still taken; no exception.
- Signed overflow (-2^(WIDTH-1) / -1):
  - Result1 = -2^(WIDTH-1); Result2 = 0.
- Operand or MCycleOp changes while COMPUTING have no effect, since the values are latched.
- Reset mid-operation: abort immediately, return to IDLE, Results cleared, Busy low at once.
- Start low during COMPUTING does not abort the operation.
- Back-to-back operations: a Start is accepted in IDLE, i.e. no earlier than 2 cycles after the previous Busy falls.

Decomposition:
- Shared package mcycle_pkg:
  - op codes: OP_SMUL, OP_UMUL, OP_SDIV, OP_UDIV.
  - state encoding: IDLE, COMPUTING, DONE.
  - WIDTH default.
- One sub-module, mcycle_sign_fix: combinational magnitude/negation conditioning, used on input and output.
- FSM, counter and shift datapath stay in mcycle_unit.

Test Plan:
- Unsigned MUL, MCycleOp=01, 0xFFFFFFFF x 0x00000002 -> Busy high exactly 33 cycles, then Result2=0x00000001, Result1=0xFFFFFFFE.
- Signed MUL, op 00, -7 x 6 -> Result1=0xFFFFFFD6, Result2=0xFFFFFFFF. Signed DIV, op 10, -7 / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
- Unsigned DIV, op 11, 100 / 7 -> Result1=14, Result2=2. DIV by 0 with Operand1=0x1234 -> Result1=0xFFFFFFFF, Result2=0x1234 after 33 busy cycles.
- Signed overflow, 0x80000000 / 0xFFFFFFFF, op 10 -> Result1=0x80000000, Result2=0.
- Start held high continuously across completion -> DONE cycle shows Busy=0, no restart that cycle. A new operation begins only on the following IDLE cycle.
- Reset asserted at cycle 10 of COMPUTING -> Busy=0 immediately, Result1=Result2=0. A subsequent Start completes normally with correct results.
